mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle CPU control unit's memory port. Accepts one
//  read or write request at a time, serves it from an internal word array after a fixed,
//  parameterised latency, and returns a one-cycle Ready strobe with read data.
//  Replaces the hard-wired memory wait states so control-unit delay states can wait on Ready.
// PARAMETERS
//  ADDR_WIDTH     8  word-index width; array holds 2**ADDR_WIDTH 32-bit words
//  READ_LATENCY   2  cycles from request capture to Ready for reads (legal 1..15)
//  WRITE_LATENCY  1  cycles from request capture to Ready for writes (legal 1..15)
// PORTS
//  Clk         in   1   rising-edge clock
//  Reset       in   1   asynchronous, active-high reset
//  Req         in   1   request strobe; sampled only when Busy=0
//  MemWrite    in   1   1=write, 0=read; sampled with Req
//  Address     in   32  byte address (from IorD mux)
//  WriteData   in   32  store data (B register); sampled with Req
//  ReadData    out  32  read result; valid in Ready cycle, held until next read completes
//  Ready       out  1   one-cycle completion pulse
//  Busy        out  1   request in flight; new Req ignored while high
//  Misaligned  out  1   pulses with Ready when captured Address[1:0] != 0
// BEHAVIOUR
//  Reset (async): state IDLE, counter 0, ReadData=0, Ready=0, Busy=0, Misaligned=0.
//   Array contents NOT cleared. Reset during a pending write aborts it (array unchanged).
//  Word index = Address[ADDR_WIDTH+1:2]; higher bits ignored (address wraps); low 2 bits
//   dropped (access aligned down) and flagged via Misaligned.
//  FSM: IDLE -> (Req) WAIT -> DONE -> IDLE or WAIT.
//   IDLE: Busy=0. Req=1 at a rising edge captures MemWrite/Address/WriteData, loads
//    counter with L-1 (L = READ_ or WRITE_LATENCY); goes WAIT if L>1, else DONE.
//   WAIT: Busy=1, Req ignored (no queueing, no error). Counter decrements each cycle;
//    goes DONE on the edge where counter reaches 1.
//   DONE: Ready=1, Busy=0, Misaligned per captured address, exactly one cycle.
//    Read: ReadData = array[index], registered on the edge entering DONE.
//    Write: array[index] <= captured WriteData on the edge entering DONE; ReadData unchanged.
//    Req in DONE is accepted exactly as in IDLE (back-to-back, no bubble); else -> IDLE.
//  Timing: Req high in cycle 0 -> Ready high in cycle L; Busy high in cycles 1..L-1.
//  Read issued in a write's Ready cycle returns the newly written data.
//  Ready, Busy, Misaligned are registered (no combinational path from Req).
//  Latency parameters outside 1..15 rejected by elaboration-time assertion.
// TESTING
//  1 Reset: assert Reset mid-cycle -> outputs 0 immediately, without waiting for a Clk edge;
//    Busy=0 after release.
//  2 Write 0xDEADBEEF @0x10, then read @0x10 (default params) -> write Ready in cycle 1;
//    read Ready 2 cycles after its Req, ReadData=0xDEADBEEF.
//  3 Read @0x20 at cycle 0, Req again at cycle 1 (Busy) -> second Req ignored; single Ready at
//    cycle 2; next Req accepted at cycle 2 -> Ready at cycle 4.
//  4 Write 0x12345678 @0x0 then read @0x403 (ADDR_WIDTH=8) -> wraps to word 0, ReadData=0x12345678,
//    Misaligned=1 with Ready.
//  5 Write @0x8 issued, Reset pulsed in cycle 1 with WRITE_LATENCY=3 -> no Ready; later read @0x8
//    returns prior contents.
//  6 READ_LATENCY=1: Req every cycle -> Ready every cycle, Busy never asserted.

Source files
------------

// File: rtl/mem_responder_if.sv
// Memory port bundle between the control unit (master) and responder (slave).
interface mem_responder_if;
  logic        Req;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic        Misaligned;

  modport master (
    output Req, MemWrite, Address, WriteData,
    input  ReadData, Ready, Busy, Misaligned
  );

  modport slave (
    input  Req, MemWrite, Address, WriteData,
    output ReadData, Ready, Busy, Misaligned
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory behind the control unit's memory port.
// One request in flight; Ready pulses for one cycle when it completes.
module mem_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  mem_responder_if.slave  bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_rl
    $error("READ_LATENCY must be 1..15");
  end
  if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_wl
    $error("WRITE_LATENCY must be 1..15");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] RL = 4'(READ_LATENCY);
  localparam logic [3:0] WL = 4'(WRITE_LATENCY);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  mis_q, mis_d;
  logic [31:0]           rdata_q, rdata_d;

  logic       accept;
  logic       enter_done;
  logic [3:0] lat;
  logic       unused_addr;

  assign unused_addr = ^bus.Address[31:ADDR_WIDTH+2];

  always_comb begin
    accept  = bus.Req && (state_q != S_WAIT);
    lat     = bus.MemWrite ? WL : RL;
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    unique case (1'b1)
      accept: begin
        we_d    = bus.MemWrite;
        idx_d   = bus.Address[ADDR_WIDTH+1:2];
        wdata_d = bus.WriteData;
        mis_d   = |bus.Address[1:0];
        cnt_d   = lat - 4'd1;
        state_d = (lat > 4'd1) ? S_WAIT : S_DONE;
      end
      (state_q == S_WAIT): begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The access itself happens on the edge entering DONE, using the
  // freshly captured request when latency is one.
  always_comb begin
    enter_done = (state_d == S_DONE);
    rdata_d    = rdata_q;
    if (enter_done && !we_d) rdata_d = mem[idx_d];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; a reset edge must not commit a write.
  always_ff @(posedge Clk) begin
    if (!Reset && enter_done && we_d) mem[idx_d] <= wdata_d;
  end

  assign bus.ReadData   = rdata_q;
  assign bus.Ready      = (state_q == S_DONE);
  assign bus.Busy       = (state_q == S_WAIT);
  assign bus.Misaligned = (state_q == S_DONE) && mis_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: default-latency responder plus a RL=1/WL=3 variant.
module tb_mem_responder;
  logic Clk;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  mem_responder_if b0 ();
  mem_responder_if b1 ();

  mem_responder u0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b0)
  );

  mem_responder #(
    .ADDR_WIDTH    (8),
    .READ_LATENCY  (1),
    .WRITE_LATENCY (3)
  ) u1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rq0(input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    b0.Req = 1'b1; b0.MemWrite = w; b0.Address = a; b0.WriteData = d;
  endtask

  task automatic rq1(input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    b1.Req = 1'b1; b1.MemWrite = w; b1.Address = a; b1.WriteData = d;
  endtask

  initial begin
    logic seen;
    Reset = 1'b1;
    b0.Req = 0; b0.MemWrite = 0; b0.Address = 0; b0.WriteData = 0;
    b1.Req = 0; b1.MemWrite = 0; b1.Address = 0; b1.WriteData = 0;
    #3;
    chk("rst_ready", {31'd0, b0.Ready}, 32'd0);
    chk("rst_busy", {31'd0, b0.Busy}, 32'd0);
    chk("rst_mis", {31'd0, b0.Misaligned}, 32'd0);
    chk("rst_rdata", b0.ReadData, 32'd0);
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("rel_busy", {31'd0, b0.Busy}, 32'd0);

    // write then read back-to-back from the write's Ready cycle
    rq0(1, 32'h10, 32'hDEADBEEF);
    tick();
    chk("wr_ready", {31'd0, b0.Ready}, 32'd1);
    chk("wr_busy", {31'd0, b0.Busy}, 32'd0);
    rq0(0, 32'h10, 32'h0);
    tick();
    b0.Req = 0;
    chk("rd_busy", {31'd0, b0.Busy}, 32'd1);
    chk("rd_noready", {31'd0, b0.Ready}, 32'd0);
    tick();
    chk("rd_ready", {31'd0, b0.Ready}, 32'd1);
    chk("rd_data", b0.ReadData, 32'hDEADBEEF);
    chk("rd_mis", {31'd0, b0.Misaligned}, 32'd0);
    tick();
    chk("rd_pulse", {31'd0, b0.Ready}, 32'd0);
    chk("rd_hold", b0.ReadData, 32'hDEADBEEF);

    // request while busy is dropped
    rq0(1, 32'h20, 32'hA5A50020);
    tick();
    b0.Req = 0;
    tick();
    rq0(0, 32'h20, 32'h0);
    tick();
    chk("ign_busy", {31'd0, b0.Busy}, 32'd1);
    rq0(0, 32'h10, 32'h0);
    tick();
    chk("ign_ready", {31'd0, b0.Ready}, 32'd1);
    chk("ign_data", b0.ReadData, 32'hA5A50020);
    tick();
    b0.Req = 0;
    chk("ign_single", {31'd0, b0.Ready}, 32'd0);
    chk("ign_busy2", {31'd0, b0.Busy}, 32'd1);
    tick();
    chk("ign_ready2", {31'd0, b0.Ready}, 32'd1);
    chk("ign_data2", b0.ReadData, 32'hDEADBEEF);
    tick();

    // address wrap and misalignment
    rq0(1, 32'h0, 32'h12345678);
    tick();
    rq0(0, 32'h403, 32'h0);
    tick();
    b0.Req = 0;
    tick();
    chk("wrap_ready", {31'd0, b0.Ready}, 32'd1);
    chk("wrap_data", b0.ReadData, 32'h12345678);
    chk("wrap_mis", {31'd0, b0.Misaligned}, 32'd1);
    tick();
    chk("wrap_mis_off", {31'd0, b0.Misaligned}, 32'd0);

    // async reset mid-cycle while a read is in flight
    rq0(0, 32'h10, 32'h0);
    tick();
    b0.Req = 0;
    chk("mid_busy_pre", {31'd0, b0.Busy}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("mid_busy", {31'd0, b0.Busy}, 32'd0);
    chk("mid_rdata", b0.ReadData, 32'd0);
    chk("mid_ready", {31'd0, b0.Ready}, 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    chk("mid_abort", {31'd0, b0.Ready}, 32'd0);
    chk("mid_idle", {31'd0, b0.Busy}, 32'd0);

    // WL=3 write, then a second write aborted by reset
    rq1(1, 32'h8, 32'h11111111);
    tick();
    b1.Req = 0;
    chk("w3_busy1", {31'd0, b1.Busy}, 32'd1);
    tick();
    chk("w3_busy2", {31'd0, b1.Busy}, 32'd1);
    tick();
    chk("w3_ready", {31'd0, b1.Ready}, 32'd1);
    tick();
    rq1(1, 32'h8, 32'h22222222);
    tick();
    b1.Req = 0;
    chk("abt_busy", {31'd0, b1.Busy}, 32'd1);
    #2 Reset = 1'b1;
    #3 Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | b1.Ready;
    end
    chk("abt_noready", {31'd0, seen}, 32'd0);
    rq1(0, 32'h8, 32'h0);
    tick();
    chk("abt_ready", {31'd0, b1.Ready}, 32'd1);
    chk("abt_data", b1.ReadData, 32'h11111111);

    // RL=1 streaming reads: Ready every cycle, never Busy
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rl1_ready%0d", i), {31'd0, b1.Ready}, 32'd1);
      chk($sformatf("rl1_busy%0d", i), {31'd0, b1.Busy}, 32'd0);
    end
    chk("rl1_data", b1.ReadData, 32'h11111111);
    b1.Req = 0;
    tick();
    chk("rl1_stop", {31'd0, b1.Ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
